// File: rtl/matrix_pkg.sv
// Shared definitions for the 3x3 matrix-multiply datapath: element widths,
// frame geometry and the operand-loader state encoding.
package matrix_pkg;

    localparam int MAT_DIM   = 3;
    localparam int ELEM_W    = 8;
    localparam int RES_W     = 16;
    // One frame carries all of A followed by all of B.
    localparam int NUM_ELEMS = 2 * MAT_DIM * MAT_DIM;

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        FIRE = 2'd1,
        HOLD = 2'd2
    } state_e;

endpackage

// File: rtl/matrix_operand_loader_if.sv
// Byte-stream valid/ready link feeding the operand loader.
interface matrix_operand_loader_if;

    logic                          in_valid;
    logic [matrix_pkg::ELEM_W-1:0] in_data;
    logic                          in_ready;

    modport master (output in_valid, output in_data, input in_ready);
    modport slave  (input in_valid, input in_data, output in_ready);

endinterface

// File: rtl/matrix_operand_loader.sv
// Assembles an 18-byte A/B frame into parallel operand registers, pulses start
// to the multiplier and freezes the operands until the multiplier reports done.
module matrix_operand_loader
    import matrix_pkg::*;
#(
    parameter int HOLD_CYCLES = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    matrix_operand_loader_if.slave s_in,
    output logic [ELEM_W-1:0]   a11,
    output logic [ELEM_W-1:0]   a12,
    output logic [ELEM_W-1:0]   a13,
    output logic [ELEM_W-1:0]   a21,
    output logic [ELEM_W-1:0]   a22,
    output logic [ELEM_W-1:0]   a23,
    output logic [ELEM_W-1:0]   a31,
    output logic [ELEM_W-1:0]   a32,
    output logic [ELEM_W-1:0]   a33,
    output logic [ELEM_W-1:0]   b11,
    output logic [ELEM_W-1:0]   b12,
    output logic [ELEM_W-1:0]   b13,
    output logic [ELEM_W-1:0]   b21,
    output logic [ELEM_W-1:0]   b22,
    output logic [ELEM_W-1:0]   b23,
    output logic [ELEM_W-1:0]   b31,
    output logic [ELEM_W-1:0]   b32,
    output logic [ELEM_W-1:0]   b33,
    output logic                start,
    input  logic                mm_done,
    output logic                busy,
    output logic [4:0]          elem_count
);

    localparam logic [4:0] LAST_IDX = 5'(NUM_ELEMS - 1);
    localparam logic [3:0] HOLD_MAX = 4'(HOLD_CYCLES);

    state_e            state_q, state_d;
    logic [4:0]        elem_count_q, elem_count_d;
    logic [3:0]        hold_cnt_q, hold_cnt_d;
    logic              start_q, start_d;
    logic              in_ready_q, in_ready_d;
    logic [ELEM_W-1:0] ops_q [NUM_ELEMS];
    logic [ELEM_W-1:0] ops_d [NUM_ELEMS];
    logic              xfer;

    assign xfer = s_in.in_valid && in_ready_q && (state_q == LOAD);

    always_comb begin
        state_d      = state_q;
        elem_count_d = elem_count_q;
        hold_cnt_d   = hold_cnt_q;
        start_d      = 1'b0;
        ops_d        = ops_q;
        if (flush) begin
            // Abort wins over any transfer or done in the same cycle.
            state_d      = LOAD;
            elem_count_d = 5'd0;
            hold_cnt_d   = 4'd0;
        end else begin
            case (state_q)
                LOAD: begin
                    if (xfer) begin
                        case (elem_count_q)
                            5'd0:    ops_d[0]  = s_in.in_data;
                            5'd1:    ops_d[1]  = s_in.in_data;
                            5'd2:    ops_d[2]  = s_in.in_data;
                            5'd3:    ops_d[3]  = s_in.in_data;
                            5'd4:    ops_d[4]  = s_in.in_data;
                            5'd5:    ops_d[5]  = s_in.in_data;
                            5'd6:    ops_d[6]  = s_in.in_data;
                            5'd7:    ops_d[7]  = s_in.in_data;
                            5'd8:    ops_d[8]  = s_in.in_data;
                            5'd9:    ops_d[9]  = s_in.in_data;
                            5'd10:   ops_d[10] = s_in.in_data;
                            5'd11:   ops_d[11] = s_in.in_data;
                            5'd12:   ops_d[12] = s_in.in_data;
                            5'd13:   ops_d[13] = s_in.in_data;
                            5'd14:   ops_d[14] = s_in.in_data;
                            5'd15:   ops_d[15] = s_in.in_data;
                            5'd16:   ops_d[16] = s_in.in_data;
                            5'd17:   ops_d[17] = s_in.in_data;
                            default: ;
                        endcase
                        elem_count_d = elem_count_q + 5'd1;
                        if (elem_count_q == LAST_IDX) begin
                            state_d = FIRE;
                            start_d = 1'b1;
                        end
                    end
                end
                FIRE: begin
                    state_d    = HOLD;
                    hold_cnt_d = 4'd0;
                end
                HOLD: begin
                    // The minimum hold must elapse first, so a sticky done cannot release early.
                    if (hold_cnt_q == HOLD_MAX && mm_done) begin
                        state_d      = LOAD;
                        elem_count_d = 5'd0;
                        hold_cnt_d   = 4'd0;
                    end else if (hold_cnt_q != HOLD_MAX) begin
                        hold_cnt_d = hold_cnt_q + 4'd1;
                    end
                end
                default: state_d = LOAD;
            endcase
        end
        // Registered so in_ready never depends combinationally on in_valid.
        in_ready_d = (state_d == LOAD);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= LOAD;
            elem_count_q <= 5'd0;
            hold_cnt_q   <= 4'd0;
            start_q      <= 1'b0;
            in_ready_q   <= 1'b0;
            for (int i = 0; i < NUM_ELEMS; i++) ops_q[i] <= '0;
        end else begin
            state_q      <= state_d;
            elem_count_q <= elem_count_d;
            hold_cnt_q   <= hold_cnt_d;
            start_q      <= start_d;
            in_ready_q   <= in_ready_d;
            ops_q        <= ops_d;
        end
    end

    assign s_in.in_ready = in_ready_q;
    assign start         = start_q;
    assign busy          = (state_q == FIRE) || (state_q == HOLD);
    assign elem_count    = elem_count_q;

    assign a11 = ops_q[0];
    assign a12 = ops_q[1];
    assign a13 = ops_q[2];
    assign a21 = ops_q[3];
    assign a22 = ops_q[4];
    assign a23 = ops_q[5];
    assign a31 = ops_q[6];
    assign a32 = ops_q[7];
    assign a33 = ops_q[8];
    assign b11 = ops_q[9];
    assign b12 = ops_q[10];
    assign b13 = ops_q[11];
    assign b21 = ops_q[12];
    assign b22 = ops_q[13];
    assign b23 = ops_q[14];
    assign b31 = ops_q[15];
    assign b32 = ops_q[16];
    assign b33 = ops_q[17];

endmodule

// File: tb/tb_matrix_operand_loader.sv
// Scoreboard bench for matrix_operand_loader: stimulus queues the frame each
// start pulse must present; a monitor checks operands whenever start fires.
module tb_matrix_operand_loader;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic flush = 1'b0;
    logic mm_done = 1'b0;
    logic start, busy;
    logic [4:0] elem_count;
    logic [7:0] a11, a12, a13, a21, a22, a23, a31, a32, a33;
    logic [7:0] b11, b12, b13, b21, b22, b23, b31, b32, b33;

    int checks = 0;
    int failures = 0;
    int start_cnt = 0;
    logic [143:0] exp_q [$];

    matrix_operand_loader_if bus ();

    matrix_operand_loader #(.HOLD_CYCLES(3)) dut (
        .clk(clk), .rst(rst), .flush(flush), .s_in(bus),
        .a11(a11), .a12(a12), .a13(a13), .a21(a21), .a22(a22), .a23(a23),
        .a31(a31), .a32(a32), .a33(a33),
        .b11(b11), .b12(b12), .b13(b13), .b21(b21), .b22(b22), .b23(b23),
        .b31(b31), .b32(b32), .b33(b33),
        .start(start), .mm_done(mm_done), .busy(busy), .elem_count(elem_count)
    );

    always #5 clk = ~clk;

    localparam logic [143:0] EXP_SEQ  = 144'h0102030405060708090a0b0c0d0e0f101112;
    localparam logic [143:0] EXP_20   = 144'h202122232425262728292a2b2c2d2e2f3031;
    localparam logic [143:0] EXP_FL7  = 144'h555555555555552728292a2b2c2d2e2f3031;
    localparam logic [143:0] EXP_FF   = {144{1'b1}};
    localparam logic [143:0] EXP_DROP = 144'h303132333435363738393a3b3c3d3e3f40ff;
    localparam logic [143:0] EXP_80   = 144'h808182838485868788898a8b8c8d8e8f9091;

    function automatic logic [143:0] dut_ops();
        return {a11, a12, a13, a21, a22, a23, a31, a32, a33,
                b11, b12, b13, b21, b22, b23, b31, b32, b33};
    endfunction

    task automatic chk(input string name, input logic [143:0] act, input logic [143:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Monitor: every start pulse must match the oldest queued frame.
    logic prev_start = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            prev_start = 1'b0;
        end else begin
            if (start) begin
                start_cnt++;
                if (prev_start) chk("start_width", 144'd2, 144'd1);
                if (exp_q.size() == 0) begin
                    chk("unexpected_start", 144'd1, 144'd0);
                end else begin
                    chk("frame_ops", dut_ops(), exp_q.pop_front());
                    chk("fire_elem_count", 144'(elem_count), 144'd18);
                    chk("fire_flags", {142'd0, busy, bus.in_ready}, 144'b10);
                end
            end
            prev_start = start;
        end
    end

    task automatic wait_ready(input string name);
        int t = 0;
        while (!bus.in_ready && t < 200) begin @(negedge clk); t++; end
        if (!bus.in_ready) chk(name, 144'd0, 144'd1);
    endtask

    task automatic send_byte(input logic [7:0] d, input logic with_flush);
        wait_ready("in_ready_timeout");
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        flush        = with_flush;
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_data  = 8'($urandom);
        flush        = 1'b0;
    endtask

    // Sends bytes 0..n-1 as base+k*step; gapped inserts an idle cycle after each.
    task automatic send_bytes(input logic [7:0] base, input logic [7:0] step, input int n,
                              input bit gapped, input string name);
        bit ok = 1'b1;
        for (int k = 0; k < n; k++) begin
            send_byte(8'(base + 8'(k) * step), 1'b0);
            if (elem_count !== 5'(k + 1)) ok = 1'b0;
            if (gapped && k != n - 1) begin
                @(negedge clk);
                if (elem_count !== 5'(k + 1)) ok = 1'b0;
            end
        end
        chk(name, 144'(ok), 144'd1);
    endtask

    initial begin
        int n;
        int s0;
        bit ok;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;

        // Reset state
        #12;
        chk("rst_ops", dut_ops(), 144'd0);
        chk("rst_flags", {136'd0, bus.in_ready, start, busy, elem_count}, 144'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", 144'(bus.in_ready), 144'd1);

        // Continuous frame 1..18 with sticky-high mm_done
        mm_done = 1'b1;
        exp_q.push_back(EXP_SEQ);
        send_bytes(8'd1, 8'd1, 18, 1'b0, "seq_count");
        chk("seq_start_now", {142'd0, start, 1'b1}, 144'b11);
        n = 0; ok = 1'b1;
        while (!bus.in_ready && n < 50) begin
            n++;
            if (dut_ops() !== EXP_SEQ) ok = 1'b0;
            @(negedge clk);
        end
        chk("sticky_hold_len", 144'(n), 144'd5);
        chk("hold_ops_stable", 144'(ok), 144'd1);
        chk("exit_elem_count", 144'(elem_count), 144'd0);

        // Gapped frame, same values
        exp_q.push_back(EXP_SEQ);
        send_bytes(8'd1, 8'd1, 18, 1'b1, "gap_count");
        wait_ready("gap_exit");

        // mm_done low for 20 cycles after start
        mm_done = 1'b0;
        exp_q.push_back(EXP_20);
        send_bytes(8'h20, 8'd1, 18, 1'b0, "done_low_count");
        ok = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (!busy || bus.in_ready) ok = 1'b0;
            @(negedge clk);
        end
        chk("done_low_hold", 144'(ok), 144'd1);
        mm_done = 1'b1;
        @(negedge clk);
        chk("done_rise_exit", {142'd0, bus.in_ready, busy}, 144'b10);

        // Flush after 7 bytes, then a full 0xFF frame
        s0 = start_cnt;
        send_bytes(8'h55, 8'd0, 7, 1'b0, "flush7_count");
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_elem_count", 144'(elem_count), 144'd0);
        chk("flush_no_start", 144'(start_cnt - s0), 144'd0);
        chk("flush_keeps_ops", dut_ops(), EXP_FL7);
        exp_q.push_back(EXP_FF);
        send_bytes(8'hFF, 8'd0, 18, 1'b0, "ff_count");
        wait_ready("ff_exit");
        chk("ff_one_start", 144'(start_cnt - s0), 144'd1);

        // Flush coincident with byte 17: dropped, no FIRE
        s0 = start_cnt;
        send_bytes(8'h30, 8'd1, 17, 1'b0, "drop_count");
        send_byte(8'h41, 1'b1);
        chk("drop_elem_count", 144'(elem_count), 144'd0);
        chk("drop_ops", dut_ops(), EXP_DROP);
        repeat (3) @(negedge clk);
        chk("drop_no_start", 144'(start_cnt - s0), 144'd0);

        // Flush during FIRE: start already pulsed, back to LOAD at once
        mm_done = 1'b0;
        exp_q.push_back(EXP_80);
        send_bytes(8'h80, 8'd1, 18, 1'b0, "fire_flush_count");
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("fire_flush_state", {142'd0, bus.in_ready, busy}, 144'b10);

        // Reset in HOLD
        exp_q.push_back(EXP_SEQ);
        send_bytes(8'd1, 8'd1, 18, 1'b0, "rst_hold_count");
        repeat (3) @(negedge clk);
        s0 = start_cnt;
        #2 rst = 1'b1;
        #1;
        chk("rst_hold_ops", dut_ops(), 144'd0);
        chk("rst_hold_flags", {136'd0, bus.in_ready, start, busy, elem_count}, 144'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        chk("rst_hold_no_start", 144'(start_cnt - s0), 144'd0);

        // Reset mid-frame
        mm_done = 1'b1;
        send_bytes(8'h10, 8'd1, 5, 1'b0, "rst_mid_count");
        #2 rst = 1'b1;
        #1;
        chk("rst_mid_ops", dut_ops(), 144'd0);
        chk("rst_mid_flags", {136'd0, bus.in_ready, start, busy, elem_count}, 144'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        chk("rst_mid_no_start", 144'(start_cnt - s0), 144'd0);
        chk("rst_mid_ready", {137'd0, bus.in_ready, elem_count}, {137'd0, 1'b1, 5'd0});

        chk("scoreboard_empty", 144'(exp_q.size()), 144'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/matrix_operand_loader.md
Name: matrix_operand_loader

Overview:
- Upstream feeder for the 3x3 matrix-multiply top.
- Accepts a byte stream over a valid/ready handshake and assembles the 18 operand bytes of A and B into stable parallel registers.
- Issues a one-cycle start pulse to the multiplier, then holds the operands stable until the multiplier has finished.
- Only then re-opens the stream for the next frame.

Parameters:
- NUM_ELEMS, 18, bytes per frame (9 for A, then 9 for B); fixed by the 3x3 x 3x3 format, not to be overridden.
- HOLD_CYCLES, 3, minimum cycles operands stay frozen after the start pulse before mm_done is honoured; range 1..15.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- flush  input  1  synchronous abort; discards the partial frame or terminates the hold.
- in_valid  input  1  stream byte valid.
- in_data  input  8  stream byte, unsigned.
- in_ready  output  1  loader can accept a byte this cycle.
- a11..a33  output  8 each  matrix A operands (nine ports), row-major.
- b11..b33  output  8 each  matrix B operands (nine ports), row-major.
- start  output  1  one-cycle pulse to the multiplier.
- mm_done  input  1  multiplier done flag; level-sensitive and may be sticky-high.
- busy  output  1  high in FIRE and HOLD.
- elem_count  output  5  bytes accepted in the current frame, 0..18.

Behaviour:
- Reset (rst high, asynchronous):
  - state=LOAD, elem_count=0, all a*/b* outputs=0.
  - start=0, busy=0, in_ready=0 while rst is asserted; in_ready=1 from the first cycle after release.
- States: LOAD, FIRE, HOLD. Encoding is 2 bits and lives in the package.
- LOAD:
  - in_ready=1.
  - A byte transfers when in_valid && in_ready at a rising edge.
  - Byte index k (0..17) is written into register k:
    - 0..8 map to a11,a12,a13,a21,a22,a23,a31,a32,a33.
    - 9..17 map to b11,b12,b13,b21,b22,b23,b31,b32,b33.
  - elem_count increments on each transfer.
  - On transfer of index 17: next state FIRE, elem_count becomes 18.
  - in_valid low means no change.
- FIRE (exactly one cycle):
  - start=1 (registered output), in_ready=0, busy=1.
  - Next state HOLD; the hold counter is cleared to 0.
- HOLD:
  - in_ready=0, busy=1, start=0.
  - Hold counter increments each cycle, saturating at HOLD_CYCLES.
  - Exit to LOAD when counter==HOLD_CYCLES and mm_done==1, checked in the same cycle.
  - On exit, elem_count is cleared to 0.
  - A sticky-high mm_done therefore cannot release the operands early.
  - mm_done low means remain in HOLD indefinitely; there is no timeout.
- Operand registers:
  - Written only in LOAD.
  - Constant from the FIRE cycle until the HOLD exit.
  - Retain their previous frame values until overwritten byte by byte.
- Latency:
  - start is asserted in the cycle after the edge that accepts byte 17.
  - in_ready is earliest high again HOLD_CYCLES+2 cycles after start rises.
- flush:
  - Highest priority after rst.
  - In any state, next state is LOAD with elem_count=0 and the hold counter cleared.
  - Operand registers are not cleared, and start is not issued.
  - flush in the same cycle as byte 17 transfers: the byte is dropped and no FIRE occurs.
  - flush during FIRE: start has already pulsed, and the loader still returns to LOAD.
- Back-pressure: in_ready depends only on state, with no combinational path from in_valid.
- Reset mid-frame or mid-hold: immediate return to reset values; no start pulse may follow.
- in_data is ignored whenever no transfer occurs.

Decomposition:
- Package matrix_pkg holds:
  - state encodings LOAD/FIRE/HOLD;
  - ELEM_W=8 and RES_W=16;
  - MAT_DIM=3;
  - NUM_ELEMS=18.
- No sub-module; the byte-index-to-register decode is a single case statement inside the block.

Test Plan:
- Reset, then stream bytes 1..18 with in_valid held high:
  - required: a11=1, a33=9, b11=10, b33=18;
  - start high for exactly one cycle, one cycle after byte 18 is accepted;
  - elem_count reads 18 during FIRE.
- mm_done tied high (sticky), HOLD_CYCLES=3: in_ready stays 0 for exactly 5 cycles starting with the FIRE cycle, then returns to 1, with operands unchanged throughout.
- Gapped stream, in_valid toggling 1,0,1,0: every byte is captured in order, elem_count only advances on transfers, and the final registers match the single-cycle-stream case.
- mm_done held low for 20 cycles after start:
  - loader stays in HOLD with busy=1 and in_ready=0;
  - it exits one cycle after mm_done rises.
- flush after 7 bytes, then a full 18-byte frame of value 0xFF:
  - elem_count is 0 after the flush and start does not pulse at the flush;
  - the next frame loads all 0xFF and produces exactly one start.
- rst asserted in HOLD and mid-frame: all outputs return to 0 asynchronously, and no start pulse occurs after release.
